frv_sha256_msched: RTL and testbench

- Sequencer for the SHA-256 small-sigma datapath: expands one 16-word message block into the schedule words W[16..ROUNDS-1].
- Produces one word per accepted output handshake.
- Sits beside the XC crypto functional unit and holds a 16-entry circular word buffer.
- Drives the two sigma functions from that buffer, so software or a hash core consumes schedule words without issuing per-word xc.sha256 instructions.

---
 rtl/frv_sha256_msched.sv | 117 +++++++++++
 tb/tb_frv_sha256_msched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_sha256_msched.sv
// SHA-256 message schedule sequencer: loads W[0..15] into a circular buffer, then streams W[16..ROUNDS-1].
// Define FRV_SHA256_MSCHED_PASSTHRU_EN to also forward the loaded words W[0..15] on the output stream.

module frv_sha256_msched #(
    parameter int ROUNDS = 64
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_index,
    output logic        done
);

    localparam logic [0:0] ST_LOAD   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;
    localparam logic [5:0] LAST_T    = 6'(ROUNDS - 1);

    logic [0:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_done;
    logic [31:0] r_buf [16];

    logic [3:0]  w_slot;
    logic [3:0]  w_m2;
    logic [3:0]  w_m7;
    logic [3:0]  w_m15;
    logic [31:0] w_next;
    logic        w_load_fire;
    logic        w_out_fire;

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Slot t[3:0] still holds W[t-16] when W[t] is computed; the sum overwrites it.
    assign w_slot = r_cnt[3:0];
    assign w_m2   = w_slot - 4'd2;
    assign w_m7   = w_slot - 4'd7;
    assign w_m15  = w_slot - 4'd15;
    assign w_next = f_s1(r_buf[w_m2]) + r_buf[w_m7] + f_s0(r_buf[w_m15]) + r_buf[w_slot];

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        load_ready = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_index  = '0;
        if (r_state == ST_EXPAND) begin
            out_valid = 1'b1;
            out_data  = w_next;
            out_index = r_cnt;
        end else begin
`ifdef FRV_SHA256_MSCHED_PASSTHRU_EN
            load_ready = out_ready;
            out_valid  = load_valid;
            out_data   = load_valid ? load_data : 32'd0;
            out_index  = r_cnt;
`else
            load_ready = 1'b1;
`endif
        end
    end

    assign w_load_fire = (r_state == ST_LOAD) && load_valid && load_ready;
    assign w_out_fire  = (r_state == ST_EXPAND) && out_ready;
    assign done        = r_done;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= ST_LOAD;
                r_cnt   <= '0;
            end else if (w_load_fire) begin
                r_cnt <= r_cnt + 6'd1;
                if (r_cnt == 6'd15) begin
                    r_state <= ST_EXPAND;
                end
            end else if (w_out_fire) begin
                if (r_cnt == LAST_T) begin
                    r_state <= ST_LOAD;
                    r_cnt   <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end
        end
    end

    // NOTE: the word buffer has no reset; it is always fully written by a load before being read.
    always_ff @(posedge g_clk) begin
        if (!flush) begin
            if (w_load_fire) begin
                r_buf[w_slot] <= load_data;
            end else if (w_out_fire) begin
                r_buf[w_slot] <= w_next;
            end
        end
    end

endmodule

// File: tb/tb_frv_sha256_msched.sv
// Self-checking bench for frv_sha256_msched: a cycle model backed by a full-schedule reference
// function is compared against the DUT every cycle, plus literal known-answer checks.

module tb_frv_sha256_msched;

    localparam int ROUNDS = 64;

    logic        g_clk      = 1'b0;
    logic        g_resetn   = 1'b0;
    logic        flush      = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data  = '0;
    logic        out_ready  = 1'b1;
    logic        load_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;
    logic [31:0] obs     [64];
    logic [31:0] ref_obs [64];

    // Model: which phase the block is in, the word index, and the loaded message words.
    bit          m_expand = 1'b0;
    int          m_k      = 0;
    bit          m_done   = 1'b0;
    logic [31:0] m_blk [16];

    frv_sha256_msched #(.ROUNDS(ROUNDS)) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .done       (done)
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] sched(input logic [31:0] blk [16], input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++) w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
        return w[t];
    endfunction

    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            m_expand <= 1'b0;
            m_k      <= 0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_expand <= 1'b0;
                m_k      <= 0;
            end else if (!m_expand) begin
`ifdef FRV_SHA256_MSCHED_PASSTHRU_EN
                if (load_valid && out_ready) begin
`else
                if (load_valid) begin
`endif
                    m_blk[m_k] <= load_data;
                    m_k        <= m_k + 1;
                    if (m_k == 15) m_expand <= 1'b1;
                end
            end else if (out_ready) begin
                if (m_k == ROUNDS - 1) begin
                    m_expand <= 1'b0;
                    m_k      <= 0;
                    m_done   <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [31:0] e_data;
        logic        e_lr, e_ov;
        int          e_idx;
        forever begin
            @(negedge g_clk);
            if (m_expand) begin
                e_lr = 1'b0; e_ov = 1'b1; e_data = sched(m_blk, m_k); e_idx = m_k;
            end else begin
`ifdef FRV_SHA256_MSCHED_PASSTHRU_EN
                e_lr = out_ready; e_ov = load_valid;
                e_data = load_valid ? load_data : 32'd0; e_idx = m_k;
`else
                e_lr = 1'b1; e_ov = 1'b0; e_data = 32'd0; e_idx = 0;
`endif
            end
            check("cyc load_ready", {31'd0, load_ready}, {31'd0, e_lr});
            check("cyc out_valid", {31'd0, out_valid}, {31'd0, e_ov});
            check($sformatf("cyc out_data k=%0d", m_k), out_data, e_data);
            check("cyc out_index", {26'd0, out_index}, 32'(e_idx));
            check("cyc done", {31'd0, done}, {31'd0, m_done});
            if (g_resetn && out_valid && out_ready) begin
                obs[out_index] = out_data;
                if (out_index >= 6'd16) n_hs++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic load_words(input logic [31:0] blk [16], input int n, input bit rnd);
        int i = 0;
        int guard = 0;
        out_ready = 1'b1;
        while (i < n && guard < 200) begin
            load_valid = !(rnd && $urandom_range(0, 3) == 0);
            load_data  = load_valid ? blk[i] : $urandom;
            cyc();
            if (load_valid) i++;
            guard++;
        end
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    task automatic expand_words(input int stall_at, input bit rnd, output bit got_done);
        int  guard = 0;
        bit  stalled = 1'b0;
        logic [31:0] held;
        got_done = 1'b0;
        while (!got_done && guard < 400) begin
            if (stall_at >= 0 && !stalled && out_index == 6'(stall_at)) begin
                held      = out_data;
                out_ready = 1'b0;
                repeat (5) begin
                    cyc();
                    check("stall out_index", {26'd0, out_index}, 32'(stall_at));
                    check("stall out_data", out_data, held);
                end
                stalled = 1'b1;
            end
            out_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_valid = $urandom_range(0, 1);
            load_data  = $urandom;
            cyc();
            if (done) begin
                got_done   = 1'b1;
                load_valid = 1'b0;
                check("load_ready at done", {31'd0, load_ready}, 32'd1);
            end
            guard++;
        end
        load_valid = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic run_block(input logic [31:0] blk [16], input int stall_at, input bit rnd);
        int start;
        bit got_done;
        start = n_hs;
        load_words(blk, 16, rnd);
        expand_words(stall_at, rnd, got_done);
        check("done pulse seen", {31'd0, got_done}, 32'd1);
        check("word count", 32'(n_hs - start), 32'(ROUNDS - 16));
    endtask

    logic [31:0] blk [16];

    initial begin
        fork
            monitor();
        join_none

        repeat (2) cyc();
        check("reset load_ready", {31'd0, load_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset out_index", {26'd0, out_index}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        g_resetn = 1'b1;
        cyc();

        // "abc" padded block
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 32'h61626380; blk[15] = 32'h00000018;
        check("model abc W16", sched(blk, 16), 32'h61626380);
        check("model abc W17", sched(blk, 17), 32'h000F0000);
        run_block(blk, -1, 1'b0);
        check("abc W16", obs[16], 32'h61626380);
        check("abc W17", obs[17], 32'h000F0000);

        // Single bit through the s0 path
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[1] = 32'h00000001;
        check("model bit W16", sched(blk, 16), 32'h02004000);
        run_block(blk, -1, 1'b0);
        check("bit W16", obs[16], 32'h02004000);

        // All-zero block
        for (int i = 0; i < 16; i++) blk[i] = '0;
        run_block(blk, -1, 1'b0);
        for (int i = 16; i < ROUNDS; i++) check($sformatf("zero W%0d", i), obs[i], 32'd0);

        // Random blocks with random gaps and backpressure
        repeat (4) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            run_block(blk, -1, 1'b1);
        end

        // Stall at t=20 must reproduce the unstalled sequence
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        run_block(blk, -1, 1'b0);
        for (int i = 16; i < ROUNDS; i++) ref_obs[i] = obs[i];
        run_block(blk, 20, 1'b0);
        for (int i = 16; i < ROUNDS; i++) check($sformatf("stalled W%0d", i), obs[i], ref_obs[i]);

        // Flush during a handshake at t=30
        begin
            int guard = 0;
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            load_words(blk, 16, 1'b1);
            out_ready = 1'b1;
            while (out_index != 6'd30 && guard < 100) begin
                cyc();
                guard++;
            end
            check("reach t=30", {26'd0, out_index}, 32'd30);
            flush = 1'b1;
            cyc();
            flush = 1'b0;
            check("flush load_ready", {31'd0, load_ready}, 32'd1);
            check("flush out_valid", {31'd0, out_valid}, 32'd0);
            check("flush done", {31'd0, done}, 32'd0);
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            run_block(blk, -1, 1'b1);
        end

        // Async reset mid-load at cnt=7
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_words(blk, 7, 1'b0);
        #2;
        g_resetn = 1'b0;
        #1;
        check("mid reset load_ready", {31'd0, load_ready}, 32'd1);
        check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid reset out_data", out_data, 32'd0);
        check("mid reset out_index", {26'd0, out_index}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        cyc();
        g_resetn = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        run_block(blk, -1, 1'b0);
        check("post reset W16", obs[16], sched(blk, 16));

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
